barrel_fetch: RTL and testbench

- Downstream consumer of barrelMath. Takes each projected source coordinate (xOut, yOut, addr_vld) and turns it into a frame-buffer read request.
- Returns fetched pixels as an in-order output stream.
- Drives mem_ready back to barrelMath as flow control. The threshold leaves enough slack to absorb barrelMath's ~16-stage pipeline after deassertion.

---
 rtl/barrel_pkg.sv | 32 +++
 rtl/barrel_fetch_if.sv | 27 ++
 rtl/sync_fifo.sv | 54 +++++
 rtl/barrel_fetch.sv | 121 ++++++++++++
 tb/tb_barrel_fetch.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/barrel_pkg.sv
// barrel_pkg: shared constants and helpers for the barrel-distortion fetch path.
// Holds source image geometry, frame-buffer layout, pixel format and the
// barrelMath pipeline depth from which the mem_ready slack is derived.
package barrel_pkg;

   localparam int unsigned WIDTH     = 960;
   localparam int unsigned HEIGHT    = 1080;
   localparam logic [31:0] BASE_ADDR = 32'h0000_0000;
   localparam int unsigned STRIDE    = 4096;
   localparam int unsigned BPP       = 4;

   localparam int unsigned      PIX_W = 24;
   localparam logic [PIX_W-1:0] BLACK = 24'h000000;

   localparam int unsigned BARREL_PIPE_DEPTH = 16;
   // barrelMath keeps issuing for its pipeline depth after mem_ready drops; the
   // extra entries cover the mem_ready register, our stage 1 and the enqueue.
   localparam int unsigned SKID = BARREL_PIPE_DEPTH + 4;

   typedef struct packed {
      logic        oob;
      logic [31:0] addr;
   } fetch_req_t;

   function automatic fetch_req_t make_req(input logic [11:0] x, input logic [11:0] y);
      fetch_req_t r;
      r.oob  = ({20'd0, x} >= WIDTH) || ({20'd0, y} >= HEIGHT);
      r.addr = BASE_ADDR + 32'(y) * STRIDE + 32'(x) * BPP;
      return r;
   endfunction

endpackage

// File: rtl/barrel_fetch_if.sv
// barrel_fetch_if: memory read channel plus output pixel stream of barrel_fetch.
//   master (barrel_fetch): drives rd_addr/rd_valid, pix_tdata/pix_tvalid;
//                          receives rd_ready, rd_data/rd_dvalid, pix_tready.
//   slave  (memory + pixel sink): the opposite directions.
interface barrel_fetch_if;
   import barrel_pkg::*;

   logic [31:0]      rd_addr;
   logic             rd_valid;
   logic             rd_ready;
   logic [PIX_W-1:0] rd_data;
   logic             rd_dvalid;
   logic [PIX_W-1:0] pix_tdata;
   logic             pix_tvalid;
   logic             pix_tready;

   modport master (
      output rd_addr, rd_valid, pix_tdata, pix_tvalid,
      input  rd_ready, rd_data, rd_dvalid, pix_tready
   );

   modport slave (
      input  rd_addr, rd_valid, pix_tdata, pix_tvalid,
      output rd_ready, rd_data, rd_dvalid, pix_tready
   );

endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO, DEPTH must be a power of two.
//   clk, reset (sync, active-low); push/wdata, pop/rdata (first-word fall-through);
//   full, empty, count. Push when full and pop when empty are ignored.
//   rdata reads as zero while empty.
module sync_fifo #(
   parameter int unsigned WIDTH_BITS = 8,
   parameter int unsigned DEPTH      = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic [WIDTH_BITS-1:0]  wdata,
   input  logic                   pop,
   output logic [WIDTH_BITS-1:0]  rdata,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);
   localparam int unsigned    AW       = $clog2(DEPTH);
   localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH_BITS-1:0] mem_q [DEPTH];
   logic [AW-1:0]         wptr_q, rptr_q;
   logic [AW:0]           count_q;
   logic                  do_push, do_pop;

   assign full    = (count_q == FULL_CNT);
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = empty ? '0 : mem_q[rptr_q];

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + 1'b1;
         if (do_pop)  rptr_q <= rptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/barrel_fetch.sv
// barrel_fetch: turns barrelMath source coordinates into frame-buffer reads and
// returns the fetched pixels as an in-order stream, black for out-of-range.
//   clk, reset          : clock, synchronous active-low reset
//   x_in, y_in, addr_vld: coordinate input (no ready, always accepted)
//   mem_ready           : flow control back to barrelMath
//   overflow            : sticky, coordinate dropped on full tag FIFO
//   bus (master)        : read request/return channel and pixel output stream
module barrel_fetch
   import barrel_pkg::*;
#(
   parameter int unsigned DEPTH   = 32,
   parameter int unsigned MAX_OUT = 16
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [11:0]    x_in,
   input  logic [11:0]    y_in,
   input  logic           addr_vld,
   output logic           mem_ready,
   output logic           overflow,
   barrel_fetch_if.master bus
);
   localparam int unsigned CW = $clog2(DEPTH) + 1;
   localparam int unsigned OW = $clog2(MAX_OUT) + 1;

   logic             s1_vld_q;
   fetch_req_t       s1_q;
   logic             tag_full, tag_empty, tag_oob, tag_push, tag_pop;
   logic [CW-1:0]    tag_count;
   logic             req_full, req_empty, req_push, req_pop;
   logic [CW-1:0]    req_count;
   logic [31:0]      req_head;
   logic             ret_full, ret_empty, ret_push, ret_pop;
   logic [OW-1:0]    ret_count;
   logic [PIX_W-1:0] ret_head;
   logic [OW-1:0]    outst_q, outst_d;
   logic             mem_ready_q, overflow_q, pix_tvalid_q, out_load;
   logic [PIX_W-1:0] pix_tdata_q;
   logic             unused_fifo;

   // Stage 1: range check and address computation.
   always_ff @(posedge clk) begin
      if (!reset) begin
         s1_vld_q <= 1'b0;
         s1_q     <= '0;
      end else begin
         s1_vld_q <= addr_vld;
         if (addr_vld) s1_q <= make_req(x_in, y_in);
      end
   end

   // Stage 2: every coordinate gets a tag; only in-range ones make a read.
   assign tag_push = s1_vld_q && !tag_full;
   assign req_push = tag_push && !s1_q.oob;

   sync_fifo #(.WIDTH_BITS(1), .DEPTH(DEPTH)) u_tag_fifo (
      .clk(clk), .reset(reset), .push(tag_push), .wdata(s1_q.oob), .pop(tag_pop),
      .rdata(tag_oob), .full(tag_full), .empty(tag_empty), .count(tag_count)
   );

   sync_fifo #(.WIDTH_BITS(32), .DEPTH(DEPTH)) u_req_fifo (
      .clk(clk), .reset(reset), .push(req_push), .wdata(s1_q.addr), .pop(req_pop),
      .rdata(req_head), .full(req_full), .empty(req_empty), .count(req_count)
   );

   sync_fifo #(.WIDTH_BITS(PIX_W), .DEPTH(MAX_OUT)) u_ret_fifo (
      .clk(clk), .reset(reset), .push(ret_push), .wdata(bus.rd_data), .pop(ret_pop),
      .rdata(ret_head), .full(ret_full), .empty(ret_empty), .count(ret_count)
   );

   assign unused_fifo = ^{req_full, req_count, ret_full};

   assign bus.rd_valid = !req_empty && (outst_q < OW'(MAX_OUT));
   assign bus.rd_addr  = req_head;
   assign req_pop      = bus.rd_valid && bus.rd_ready;

   // Only accept a beat that matches a request still awaiting data; stale beats
   // from reads issued before a reset find no such request and are dropped.
   assign ret_push = bus.rd_dvalid && (ret_count < outst_q);

   // Output slot refills when empty or being consumed; in-range tags wait for data.
   assign out_load = (!pix_tvalid_q || bus.pix_tready) && !tag_empty &&
                     (tag_oob || !ret_empty);
   assign tag_pop  = out_load;
   assign ret_pop  = out_load && !tag_oob;

   always_comb begin
      outst_d = outst_q;
      case ({req_pop, ret_pop})
         2'b10:   outst_d = outst_q + 1'b1;
         2'b01:   outst_d = outst_q - 1'b1;
         default: outst_d = outst_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         outst_q      <= '0;
         mem_ready_q  <= 1'b0;
         overflow_q   <= 1'b0;
         pix_tvalid_q <= 1'b0;
         pix_tdata_q  <= '0;
      end else begin
         outst_q     <= outst_d;
         mem_ready_q <= (DEPTH - 32'(tag_count)) > SKID;
         if (s1_vld_q && tag_full) overflow_q <= 1'b1;
         if (out_load) begin
            pix_tvalid_q <= 1'b1;
            pix_tdata_q  <= tag_oob ? BLACK : ret_head;
         end else if (bus.pix_tready) begin
            pix_tvalid_q <= 1'b0;
         end
      end
   end

   assign mem_ready      = mem_ready_q;
   assign overflow       = overflow_q;
   assign bus.pix_tvalid = pix_tvalid_q;
   assign bus.pix_tdata  = pix_tdata_q;

endmodule

// File: tb/tb_barrel_fetch.sv
// tb_barrel_fetch: directed + randomized bench for barrel_fetch. A frame-buffer
// model with configurable latency answers reads; expected addresses and pixels
// come from the coordinate rules (range limits, y*stride + x*bpp).
module tb_barrel_fetch;

   logic        clk = 1'b0;
   logic        reset;
   logic [11:0] x_in, y_in;
   logic        addr_vld;
   logic        mem_ready, overflow;

   barrel_fetch_if bus ();

   barrel_fetch dut (
      .clk(clk), .reset(reset), .x_in(x_in), .y_in(y_in), .addr_vld(addr_vld),
      .mem_ready(mem_ready), .overflow(overflow), .bus(bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [31:0] exp_addr_q[$];
   logic [23:0] exp_pix_q[$];
   logic [31:0] pend_addr[$];
   int          pend_due[$];

   int   lat = 3;
   bit   rr_mode = 1'b0;
   bit   pr_rand = 1'b0;
   int   n_req = 0, n_pix = 0, max_pend = 0;
   bit   saw_mr_low = 1'b0, saw_pv = 1'b0;
   logic [23:0] last_pix = '0;

   bit          prev_rv = 1'b0, prev_rr = 1'b0, prev_pv = 1'b0, prev_pr = 1'b0;
   logic [31:0] prev_ra = '0;
   logic [23:0] prev_pd = '0;

   function automatic logic [23:0] pix_of(input logic [31:0] a);
      if (a == 32'h0000_2028) return 24'hABCDEF;
      return a[25:2] ^ 24'h5A5A5A;
   endfunction

   function automatic void model_push(input logic [11:0] x, input logic [11:0] y);
      logic [31:0] a;
      if (int'(x) >= 960 || int'(y) >= 1080) begin
         exp_pix_q.push_back(24'h000000);
      end else begin
         a = 32'(y) * 32'd4096 + 32'(x) * 32'd4;
         exp_addr_q.push_back(a);
         exp_pix_q.push_back(pix_of(a));
      end
   endfunction

   // One cycle: check holds, drive coordinate, run memory model and pixel sink.
   task automatic step(input bit vld, input logic [11:0] x, input logic [11:0] y);
      logic [31:0] exp_a;
      logic [23:0] exp_p;
      @(negedge clk);
      cyc++;
      if (reset && prev_rv && !prev_rr) begin
         checks++;
         assert (bus.rd_valid === 1'b1 && bus.rd_addr === prev_ra) else begin
            errors++;
            $error("FAIL rd_hold got v=%b a=%h exp v=1 a=%h", bus.rd_valid, bus.rd_addr, prev_ra);
         end
      end
      if (reset && prev_pv && !prev_pr) begin
         checks++;
         assert (bus.pix_tvalid === 1'b1 && bus.pix_tdata === prev_pd) else begin
            errors++;
            $error("FAIL pix_hold got v=%b d=%h exp v=1 d=%h", bus.pix_tvalid, bus.pix_tdata,
                   prev_pd);
         end
      end
      addr_vld = vld;
      x_in     = x;
      y_in     = y;
      if (vld) model_push(x, y);
      bus.rd_ready   = rr_mode;
      bus.pix_tready = pr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      // memory returns, in order, at most one per cycle
      if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
         bus.rd_dvalid = 1'b1;
         bus.rd_data   = pix_of(pend_addr[0]);
         void'(pend_addr.pop_front());
         void'(pend_due.pop_front());
      end else begin
         bus.rd_dvalid = 1'b0;
         bus.rd_data   = 24'h0;
      end
      if (bus.rd_valid === 1'b1 && bus.rd_ready) begin
         exp_a = (exp_addr_q.size() > 0) ? exp_addr_q[0] : 32'hxxxx_xxxx;
         checks++;
         assert (bus.rd_addr === exp_a) else begin
            errors++;
            $error("FAIL rd_addr got %h exp %h", bus.rd_addr, exp_a);
         end
         if (exp_addr_q.size() > 0) void'(exp_addr_q.pop_front());
         pend_addr.push_back(bus.rd_addr);
         pend_due.push_back(cyc + lat);
         n_req++;
         if (pend_addr.size() > max_pend) max_pend = pend_addr.size();
      end
      if (bus.pix_tvalid === 1'b1 && bus.pix_tready) begin
         exp_p = (exp_pix_q.size() > 0) ? exp_pix_q[0] : 24'hxxxxxx;
         checks++;
         assert (bus.pix_tdata === exp_p) else begin
            errors++;
            $error("FAIL pix_data got %h exp %h", bus.pix_tdata, exp_p);
         end
         if (exp_pix_q.size() > 0) void'(exp_pix_q.pop_front());
         n_pix++;
         last_pix = bus.pix_tdata;
      end
      if (reset && mem_ready === 1'b0) saw_mr_low = 1'b1;
      if (bus.pix_tvalid === 1'b1) saw_pv = 1'b1;
      prev_rv = reset && (bus.rd_valid === 1'b1);
      prev_rr = bus.rd_ready;
      prev_ra = bus.rd_addr;
      prev_pv = reset && (bus.pix_tvalid === 1'b1);
      prev_pr = bus.pix_tready;
      prev_pd = bus.pix_tdata;
   endtask

   task automatic drain(input string tag, input int bound);
      int k = 0;
      while ((exp_pix_q.size() > 0 || pend_addr.size() > 0 || exp_addr_q.size() > 0) &&
             k < bound) begin
         step(1'b0, 12'd0, 12'd0);
         k++;
      end
      checks++;
      assert (exp_pix_q.size() == 0 && pend_addr.size() == 0 && exp_addr_q.size() == 0) else begin
         errors++;
         $error("FAIL %s_drain got pix_left=%0d req_left=%0d exp 0", tag, exp_pix_q.size(),
                pend_addr.size());
      end
   endtask

   // barrelMath model: addr_vld follows mem_ready delayed by its pipeline depth.
   task automatic stream(input int n, input int bound, output int sent);
      bit hist[$];
      bit v;
      sent = 0;
      for (int i = 0; i < 16; i++) hist.push_back(mem_ready === 1'b1);
      for (int t = 0; t < bound && sent < n; t++) begin
         v = hist.pop_front();
         if (v) begin
            step(1'b1, 12'($urandom_range(0, 1023)), 12'($urandom_range(0, 1151)));
            sent++;
         end else begin
            step(1'b0, 12'd0, 12'd0);
         end
         hist.push_back(mem_ready === 1'b1);
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      int s1, s2, req0, pix0, k;
      reset          = 1'b0;
      addr_vld       = 1'b0;
      x_in           = '0;
      y_in           = '0;
      bus.rd_ready   = 1'b0;
      bus.rd_data    = '0;
      bus.rd_dvalid  = 1'b0;
      bus.pix_tready = 1'b0;

      // 1: reset held 10 cycles, mem_ready rises right after release
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 12'd0, 12'd0);
         chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
         chk("rst_pix_tvalid", 32'(bus.pix_tvalid), 32'd0);
      end
      chk("rst_mem_ready", 32'(mem_ready), 32'd0);
      chk("rst_rd_addr", bus.rd_addr, 32'd0);
      chk("rst_pix_tdata", 32'(bus.pix_tdata), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      reset = 1'b1;
      step(1'b0, 12'd0, 12'd0);
      chk("mem_ready_rise", 32'(mem_ready), 32'd1);

      // 2: single coordinate, two-cycle request latency, known pixel
      rr_mode = 1'b1;
      lat     = 3;
      step(1'b1, 12'd10, 12'd2);
      step(1'b0, 12'd0, 12'd0);
      chk("lat1_rd_valid", 32'(bus.rd_valid), 32'd0);
      step(1'b0, 12'd0, 12'd0);
      chk("lat2_rd_valid", 32'(bus.rd_valid), 32'd1);
      chk("lat2_rd_addr", bus.rd_addr, 32'h0000_2028);
      drain("t2", 100);
      chk("t2_pixel", 32'(last_pix), 32'h00AB_CDEF);

      // 3: mixed in-range / out-of-range order
      req0 = n_req;
      pix0 = n_pix;
      step(1'b1, 12'd5, 12'd5);
      step(1'b1, 12'd960, 12'd0);
      step(1'b1, 12'd0, 12'd1080);
      step(1'b1, 12'd7, 12'd7);
      drain("t3", 200);
      chk("t3_req_count", 32'(n_req - req0), 32'd2);
      chk("t3_pix_count", 32'(n_pix - pix0), 32'd4);

      // 4: backpressure with rd_ready low, then release
      rr_mode    = 1'b0;
      saw_mr_low = 1'b0;
      pix0       = n_pix;
      stream(100, 60, s1);
      chk("t4_mem_ready_fell", 32'(saw_mr_low), 32'd1);
      chk("t4_throttled", 32'(s1 < 100), 32'd1);
      chk("t4_rd_valid_held", 32'(bus.rd_valid), 32'd1);
      chk("t4_overflow_a", 32'(overflow), 32'd0);
      rr_mode = 1'b1;
      stream(100 - s1, 3000, s2);
      drain("t4", 3000);
      chk("t4_sent", 32'(s1 + s2), 32'd100);
      chk("t4_pix_count", 32'(n_pix - pix0), 32'd100);
      chk("t4_overflow_b", 32'(overflow), 32'd0);

      // 5: long memory latency, random downstream stalls
      lat      = 40;
      pr_rand  = 1'b1;
      max_pend = 0;
      pix0     = n_pix;
      stream(60, 3000, s1);
      drain("t5", 5000);
      pr_rand = 1'b0;
      chk("t5_max_outstanding", 32'(max_pend), 32'd16);
      chk("t5_pix_count", 32'(n_pix - pix0), 32'(s1));
      chk("t5_overflow", 32'(overflow), 32'd0);

      // 6: reset with reads in flight, late returns must be ignored
      lat = 40;
      for (int i = 0; i < 8; i++) step(1'b1, 12'(i * 3), 12'(i));
      k = 0;
      while (pend_addr.size() < 8 && k < 50) begin
         step(1'b0, 12'd0, 12'd0);
         k++;
      end
      chk("t6_outstanding", 32'(pend_addr.size()), 32'd8);
      reset = 1'b0;
      step(1'b0, 12'd0, 12'd0);
      chk("t6_rd_valid", 32'(bus.rd_valid), 32'd0);
      chk("t6_pix_tvalid", 32'(bus.pix_tvalid), 32'd0);
      chk("t6_rd_addr", bus.rd_addr, 32'd0);
      chk("t6_pix_tdata", 32'(bus.pix_tdata), 32'd0);
      chk("t6_mem_ready", 32'(mem_ready), 32'd0);
      exp_addr_q.delete();
      exp_pix_q.delete();
      reset  = 1'b1;
      saw_pv = 1'b0;
      for (int i = 0; i < 60; i++) step(1'b0, 12'd0, 12'd0);
      chk("t6_late_beats_done", 32'(pend_addr.size()), 32'd0);
      chk("t6_no_pix", 32'(saw_pv), 32'd0);
      lat  = 3;
      pix0 = n_pix;
      step(1'b1, 12'd3, 12'd4);
      drain("t6", 200);
      chk("t6_recover", 32'(n_pix - pix0), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
